// File: rtl/reg_wall_write_arbiter_if.sv
// Writeback request bundle between NUM_REQ sources and the register-wall write arbiter.
// Source i owns bits [i*IDX_W +: IDX_W] of req_idx and [i*DATA_W +: DATA_W] of req_data.
interface reg_wall_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 65,
  parameter int IDX_W   = 5
);
  // Handshake: a source raises req_valid[i] with stable req_idx/req_data and keeps
  // them until it sees req_ready[i]; the transfer happens on the rising edge where
  // req_valid[i] & req_ready[i]. req_ready is combinational and at most one-hot.
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*IDX_W-1:0]  req_idx;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (output req_valid, output req_idx, output req_data, input req_ready);
  modport slave  (input req_valid, input req_idx, input req_data, output req_ready);
endinterface

// File: rtl/reg_wall_write_arbiter.sv
// Round-robin arbiter for the single register-wall write port: grants one writeback
// source per cycle, registers its data/index, and tracks which entries have been written.
module reg_wall_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 65,
  parameter int NUM_ENTRIES = 32,
  parameter int IDX_W       = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  reg_wall_write_arbiter_if.slave req,
  input  logic                   stall,
  input  logic                   clear_valid,
  input  logic [IDX_W-1:0]       clear_idx,
  output logic [NUM_ENTRIES-1:0] wall_enable,
  output logic [DATA_W-1:0]      wall_d,
  output logic [NUM_ENTRIES-1:0] entry_written,
  output logic                   busy
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       win;
  logic [PTR_W-1:0]       cand;
  logic [PTR_W-1:0]       next_ptr;
  logic [PTR_W:0]         sum;
  logic                   found;
  logic                   fire;
  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       win_idx;
  logic [DATA_W-1:0]      win_data;
  logic [NUM_ENTRIES-1:0] clear_mask;
  logic [NUM_ENTRIES-1:0] en_q;
  logic [DATA_W-1:0]      wall_d_q;
  logic                   busy_q;

  // First valid source at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      cand = sum[PTR_W-1:0];
      if (!found && req.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign fire = found & ~stall & ~reset;

  always_comb begin
    grant = '0;
    if (fire) grant[win] = 1'b1;
  end

  assign req.req_ready = grant;
  assign win_idx       = req.req_idx[int'(win)*IDX_W +: IDX_W];
  assign win_data      = req.req_data[int'(win)*DATA_W +: DATA_W];
  assign next_ptr      = (win == PTR_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
  assign clear_mask    = clear_valid ? (NUM_ENTRIES'(1) << clear_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr        <= '0;
      en_q          <= '0;
      wall_d_q      <= '0;
      busy_q        <= 1'b0;
      entry_written <= '0;
    end else begin
      if (fire) begin
        rr_ptr   <= next_ptr;
        en_q     <= NUM_ENTRIES'(1) << win_idx;
        wall_d_q <= win_data;
        busy_q   <= 1'b1;
      end else begin
        en_q   <= '0;
        busy_q <= 1'b0;
      end
      // A write landing on this edge beats a clear of the same entry.
      entry_written <= (entry_written & ~clear_mask) | en_q;
    end
  end

  // Reset masks an in-flight write so the walls never capture it.
  assign wall_enable = en_q & {NUM_ENTRIES{~reset}};
  assign busy        = busy_q & ~reset;
  assign wall_d      = wall_d_q;
endmodule

// File: tb/tb_reg_wall_write_arbiter.sv
// Bench for reg_wall_write_arbiter: directed scenarios plus a randomized run checked
// against a cycle-level reference model and an expected-data queue.
module tb_reg_wall_write_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 65;
  localparam int NUM_ENTRIES = 32;
  localparam int IDX_W       = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   stall;
  logic                   clear_valid;
  logic [IDX_W-1:0]       clear_idx;
  logic [NUM_ENTRIES-1:0] wall_enable;
  logic [DATA_W-1:0]      wall_d;
  logic [NUM_ENTRIES-1:0] entry_written;
  logic                   busy;

  reg_wall_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .IDX_W(IDX_W)) rif();

  reg_wall_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .req(rif), .stall(stall),
    .clear_valid(clear_valid), .clear_idx(clear_idx),
    .wall_enable(wall_enable), .wall_d(wall_d),
    .entry_written(entry_written), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  int                     m_ptr = 0;
  logic [NUM_ENTRIES-1:0] m_en = '0;
  logic                   m_busy = 1'b0;
  logic [NUM_ENTRIES-1:0] m_written = '0;
  logic [NUM_REQ-1:0]     m_last_grant = '0;
  logic [DATA_W-1:0]      exp_q[$];

  function automatic logic [NUM_REQ-1:0] model_grant();
    if (reset || stall) return '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int s;
      s = (m_ptr + k) % NUM_REQ;
      if (rif.req_valid[s]) return NUM_REQ'(1) << s;
    end
    return '0;
  endfunction

  // Advance one clock and update the model with the inputs held during that cycle.
  task automatic tick();
    logic [NUM_REQ-1:0] g;
    @(posedge clk);
    g = model_grant();
    m_last_grant = g;
    if (reset) begin
      m_ptr = 0; m_en = '0; m_busy = 1'b0; m_written = '0;
      exp_q.delete();
    end else begin
      if (clear_valid) m_written[clear_idx] = 1'b0;
      m_written = m_written | m_en;
      m_en = '0;
      m_busy = 1'b0;
      for (int s = 0; s < NUM_REQ; s++) begin
        if (g[s]) begin
          m_en   = NUM_ENTRIES'(1) << rif.req_idx[s*IDX_W +: IDX_W];
          m_busy = 1'b1;
          m_ptr  = (s + 1) % NUM_REQ;
          exp_q.push_back(rif.req_data[s*DATA_W +: DATA_W]);
        end
      end
    end
    #1;
  endtask

  task automatic set_req(input int s, input logic v, input logic [IDX_W-1:0] idx,
                         input logic [DATA_W-1:0] data);
    rif.req_valid[s] = v;
    rif.req_idx[s*IDX_W +: IDX_W] = idx;
    rif.req_data[s*DATA_W +: DATA_W] = data;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; clear_valid = 1'b0;
    rif.req_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rif.req_valid = '1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_total++;
      if (rif.req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", rif.req_ready);
      else n_pass++;
      n_total++;
      if (wall_enable !== '0 || busy !== 1'b0)
        $display("FAIL reset_wall: wall_enable %h busy %b want 0/0", wall_enable, busy);
      else n_pass++;
      n_total++;
      if (entry_written !== '0) $display("FAIL reset_written: got %h want 0", entry_written);
      else n_pass++;
      tick();
    end
    reset = 1'b0;
    rif.req_valid = '0;
  endtask

  task automatic test_single_write();
    logic [DATA_W-1:0] d;
    do_reset();
    d = 65'h1_DEAD_BEEF_0000_0001;
    set_req(2, 1'b1, 5'd5, d);
    @(negedge clk);
    n_total++;
    if (rif.req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", rif.req_ready);
    else n_pass++;
    tick();
    rif.req_valid = '0;
    @(negedge clk);
    n_total++;
    if (wall_enable !== 32'h0000_0020 || busy !== 1'b1)
      $display("FAIL single_enable: got %h busy %b want 00000020 busy 1", wall_enable, busy);
    else n_pass++;
    n_total++;
    if (wall_d !== d) $display("FAIL single_data: got %h want %h", wall_d, d);
    else n_pass++;
    n_total++;
    if (entry_written[5] !== 1'b0) $display("FAIL single_early: entry_written[5] got 1 want 0");
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (entry_written !== 32'h0000_0020 || wall_enable !== '0)
      $display("FAIL single_written: written %h enable %h want 00000020/0", entry_written, wall_enable);
    else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    int cnt[NUM_REQ];
    logic [NUM_REQ-1:0] exp_g;
    logic [NUM_ENTRIES-1:0] exp_en;
    do_reset();
    for (int s = 0; s < NUM_REQ; s++) begin
      cnt[s] = 0;
      set_req(s, 1'b1, IDX_W'(s), DATA_W'(s + 100));
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_g = NUM_REQ'(1) << (c % NUM_REQ);
      n_total++;
      if (rif.req_ready !== exp_g) $display("FAIL rr_grant c%0d: got %b want %b", c, rif.req_ready, exp_g);
      else n_pass++;
      for (int s = 0; s < NUM_REQ; s++) if (rif.req_ready[s]) cnt[s]++;
      if (c > 0) begin
        exp_en = NUM_ENTRIES'(1) << ((c - 1) % NUM_REQ);
        n_total++;
        if (wall_enable !== exp_en) $display("FAIL rr_enable c%0d: got %h want %h", c, wall_enable, exp_en);
        else n_pass++;
      end
      tick();
    end
    for (int s = 0; s < NUM_REQ; s++) begin
      n_total++;
      if (cnt[s] != 2) $display("FAIL rr_count s%0d: got %0d want 2", s, cnt[s]);
      else n_pass++;
    end
    rif.req_valid = '0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    for (int s = 0; s < NUM_REQ; s++) set_req(s, 1'b1, IDX_W'(10 + s), DATA_W'(s + 7));
    @(negedge clk);
    n_total++;
    if (rif.req_ready !== 4'b0001) $display("FAIL stall_first: got %b want 0001", rif.req_ready);
    else n_pass++;
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if (rif.req_ready !== 4'b0000) $display("FAIL stall_ready k%0d: got %b want 0000", k, rif.req_ready);
      else n_pass++;
      n_total++;
      if (k == 0 && (wall_enable !== 32'h0000_0400 || busy !== 1'b1))
        $display("FAIL stall_inflight: got %h busy %b want 00000400 busy 1", wall_enable, busy);
      else if (k != 0 && wall_enable !== '0)
        $display("FAIL stall_idle k%0d: got %h want 0", k, wall_enable);
      else n_pass++;
      tick();
    end
    stall = 1'b0;
    @(negedge clk);
    n_total++;
    if (rif.req_ready !== 4'b0010) $display("FAIL stall_resume: got %b want 0010", rif.req_ready);
    else n_pass++;
    n_total++;
    if (entry_written !== 32'h0000_0400) $display("FAIL stall_written: got %h want 00000400", entry_written);
    else n_pass++;
    tick();
    rif.req_valid = '0;
    tick();
  endtask

  task automatic test_clear_collision();
    do_reset();
    set_req(0, 1'b1, 5'd7, 65'h0_1234_5678_9ABC_DEF0);
    @(negedge clk);
    n_total++;
    if (rif.req_ready !== 4'b0001) $display("FAIL clr_grant: got %b want 0001", rif.req_ready);
    else n_pass++;
    tick();
    rif.req_valid = '0;
    clear_valid = 1'b1; clear_idx = 5'd7;
    @(negedge clk);
    n_total++;
    if (wall_enable !== 32'h0000_0080) $display("FAIL clr_enable: got %h want 00000080", wall_enable);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (entry_written[7] !== 1'b1) $display("FAIL clr_collision: entry_written[7] got %b want 1", entry_written[7]);
    else n_pass++;
    tick();
    clear_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (entry_written[7] !== 1'b0) $display("FAIL clr_alone: entry_written[7] got %b want 0", entry_written[7]);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_req(1, 1'b1, 5'd9, 65'h1_0000_0000_0000_0009);
    @(negedge clk);
    n_total++;
    if (rif.req_ready !== 4'b0010) $display("FAIL mid_grant: got %b want 0010", rif.req_ready);
    else n_pass++;
    tick();
    rif.req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (wall_enable !== '0 || busy !== 1'b0)
      $display("FAIL mid_drop: wall_enable %h busy %b want 0/0", wall_enable, busy);
    else n_pass++;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_total++;
      if (wall_enable !== '0 || entry_written[9] !== 1'b0)
        $display("FAIL mid_after k%0d: wall_enable %h written[9] %b want 0/0", k, wall_enable, entry_written[9]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    int wait_cnt[NUM_REQ];
    logic [NUM_REQ-1:0] exp_g;
    logic [NUM_ENTRIES-1:0] exp_en;
    logic [DATA_W-1:0] exp_d;
    do_reset();
    for (int s = 0; s < NUM_REQ; s++) wait_cnt[s] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int s = 0; s < NUM_REQ; s++) begin
        if (!rif.req_valid[s] && $urandom_range(0, 1) == 1) begin
          set_req(s, 1'b1, IDX_W'($urandom_range(0, 7)), DATA_W'({$urandom, $urandom, $urandom}));
          wait_cnt[s] = 0;
        end
      end
      stall       = ($urandom_range(0, 7) == 0);
      clear_valid = ($urandom_range(0, 3) == 0);
      clear_idx   = IDX_W'($urandom_range(0, 7));
      reset       = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      exp_g  = model_grant();
      exp_en = reset ? '0 : m_en;
      n_total++;
      if (rif.req_ready !== exp_g) $display("FAIL rnd_grant c%0d: got %b want %b", c, rif.req_ready, exp_g);
      else n_pass++;
      n_total++;
      if (wall_enable !== exp_en || busy !== (m_busy & ~reset))
        $display("FAIL rnd_enable c%0d: got %h busy %b want %h busy %b", c, wall_enable, busy, exp_en, m_busy & ~reset);
      else n_pass++;
      n_total++;
      if (entry_written !== m_written) $display("FAIL rnd_written c%0d: got %h want %h", c, entry_written, m_written);
      else n_pass++;
      if (!reset && m_en != '0) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL rnd_data c%0d: got %h want queued data (queue empty)", c, wall_d);
        else begin
          exp_d = exp_q.pop_front();
          if (wall_d !== exp_d) $display("FAIL rnd_data c%0d: got %h want %h", c, wall_d, exp_d);
          else n_pass++;
        end
      end
      for (int s = 0; s < NUM_REQ; s++) begin
        if (reset) wait_cnt[s] = 0;
        else if (rif.req_valid[s] && !stall) begin
          wait_cnt[s]++;
          if (rif.req_ready[s]) begin
            n_total++;
            if (wait_cnt[s] > NUM_REQ) $display("FAIL rnd_fair s%0d: got %0d cycles want <= %0d", s, wait_cnt[s], NUM_REQ);
            else n_pass++;
          end
        end
      end
      tick();
      for (int s = 0; s < NUM_REQ; s++) if (m_last_grant[s]) rif.req_valid[s] = 1'b0;
    end
    reset = 1'b0; stall = 1'b0; clear_valid = 1'b0;
    rif.req_valid = '0;
    tick();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; clear_valid = 1'b0; clear_idx = '0;
    rif.req_valid = '0; rif.req_idx = '0; rif.req_data = '0;
    #1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_stall();
    test_clear_collision();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
